// File: rtl/m6809_pkg.sv
// Shared types for the m6809 16-bit ALU sequencer.
// States, operation classes, CC bit indices, opcode class decode.
package m6809_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_HI = 3'd1,
    S_RD_LO = 3'd2,
    S_EXEC  = 3'd3,
    S_WR_HI = 3'd4,
    S_WR_LO = 3'd5,
    S_FIN   = 3'd6
  } st_e;

  typedef enum logic [2:0] {
    OPC_LD  = 3'd0,
    OPC_ST  = 3'd1,
    OPC_CMP = 3'd2,
    OPC_ADD = 3'd3,
    OPC_SUB = 3'd4
  } opc_e;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  // Nibble 3: SUBD/ADDD, CMPD (page2), CMPU (page3).
  // Nibble C with bit6 clear: CMPX/CMPY/CMPS.
  function automatic opc_e op_class(
    input logic [3:0] op,
    input logic       op6,
    input logic       p2,
    input logic       p3,
    input logic       st
  );
    opc_e c;
    logic n3;
    logic nc;
    c  = OPC_LD;
    n3 = !st && (op == 4'h3);
    nc = !st && (op == 4'hC);
    unique case (1'b1)
      st:                       c = OPC_ST;
      n3 && op6:                c = OPC_ADD;
      n3 && !op6 && (p2 || p3): c = OPC_CMP;
      n3 && !op6 && !p2 && !p3: c = OPC_SUB;
      nc && !op6:               c = OPC_CMP;
      default:                  c = OPC_LD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/m6809_alu16_seq_alu16.sv
// alu16: 16-bit add/sub/pass for the m6809 D/X/Y/U/S ops.
// Ports: cls, in_a (operand), in_b (register), c_in, v_in -> out, n, z, v_out, c_out.
module alu16
  import m6809_pkg::*;
(
  input  opc_e        cls,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        c_in,
  input  logic        v_in,
  output logic [15:0] out,
  output logic        n,
  output logic        z,
  output logic        v_out,
  output logic        c_out
);

  logic [16:0] sum;

  always_comb begin
    sum   = '0;
    out   = in_a;
    v_out = v_in;
    c_out = c_in;
    unique case (1'b1)
      cls == OPC_ADD: begin
        sum   = {1'b0, in_b} + {1'b0, in_a};
        out   = sum[15:0];
        c_out = sum[16];
        v_out = (in_a[15] == in_b[15]) &&
                (out[15] != in_b[15]);
      end
      (cls == OPC_SUB) || (cls == OPC_CMP): begin
        // bit 16 of the widened difference is the borrow
        sum   = {1'b0, in_b} - {1'b0, in_a};
        out   = sum[15:0];
        c_out = sum[16];
        v_out = (in_a[15] != in_b[15]) &&
                (out[15] != in_b[15]);
      end
      default: ;
    endcase
    n = out[15];
    z = (out == 16'h0000);
  end

endmodule

// File: rtl/m6809_alu16_seq.sv
// Sequencer: fetches/stores a big-endian 16-bit operand over an 8-bit bus, runs alu16.
// Ports: start/decode/ea/imm/reg/cc in; mem_* bus; busy/done/err/wb_en/result/cc_out.
module m6809_alu16_seq
  import m6809_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        op6,
  input  logic        page2,
  input  logic        page3,
  input  logic        is_store,
  input  logic        is_imm,
  input  logic [15:0] ea,
  input  logic [15:0] imm_val,
  input  logic [15:0] reg_val,
  input  logic [3:0]  cc_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_en,
  output logic [15:0] result,
  output logic [3:0]  cc_out
);

  localparam int WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  st_e         state;
  st_e         nxt;
  opc_e        cls_q;
  logic [15:0] ea_q;
  logic [15:0] reg_q;
  logic [15:0] opnd_q;
  logic        c_q;
  logic        v_q;
  logic        err_q;
  logic [WCW-1:0] wcnt;

  logic        tmo;
  logic        nx_req;
  logic        nx_we;
  logic [15:0] nx_addr;
  logic [7:0]  nx_wdata;
  logic [15:0] base_ea;
  logic [15:0] base_reg;

  logic [15:0] alu_out;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        alu_c;
  logic        unused_cc;

  // N/Z of the incoming flags are always recomputed
  assign unused_cc = cc_in[CC_N] ^ cc_in[CC_Z];

  alu16 u_alu16 (
    .cls   (cls_q),
    .in_a  (opnd_q),
    .in_b  (reg_q),
    .c_in  (c_q),
    .v_in  (v_q),
    .out   (alu_out),
    .n     (alu_n),
    .z     (alu_z),
    .v_out (alu_v),
    .c_out (alu_c)
  );

  always_comb begin
    nxt = state;
    tmo = (MAX_WAIT != 0) && !mem_ack &&
          (wcnt == WCW'(MAX_WAIT - 1));
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (is_store)    nxt = S_WR_HI;
          else if (is_imm) nxt = S_EXEC;
          else             nxt = S_RD_HI;
        end
      end
      S_RD_HI: begin
        if (mem_ack)  nxt = S_RD_LO;
        else if (tmo) nxt = S_FIN;
      end
      S_RD_LO: begin
        if (mem_ack)  nxt = S_EXEC;
        else if (tmo) nxt = S_FIN;
      end
      S_WR_HI: begin
        if (mem_ack)  nxt = S_WR_LO;
        else if (tmo) nxt = S_FIN;
      end
      S_WR_LO: begin
        if (mem_ack)  nxt = S_EXEC;
        else if (tmo) nxt = S_FIN;
      end
      S_EXEC:  nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so the
  // request appears together with the state that owns it.
  always_comb begin
    base_ea  = (state == S_IDLE) ? ea : ea_q;
    base_reg = (state == S_IDLE) ? reg_val : reg_q;
    nx_req   = 1'b0;
    nx_we    = 1'b0;
    nx_addr  = mem_addr;
    nx_wdata = mem_wdata;
    unique case (nxt)
      S_RD_HI: begin
        nx_req  = 1'b1;
        nx_addr = base_ea;
      end
      S_RD_LO: begin
        nx_req  = 1'b1;
        nx_addr = base_ea + 16'd1;
      end
      S_WR_HI: begin
        nx_req   = 1'b1;
        nx_we    = 1'b1;
        nx_addr  = base_ea;
        nx_wdata = base_reg[15:8];
      end
      S_WR_LO: begin
        nx_req   = 1'b1;
        nx_we    = 1'b1;
        nx_addr  = base_ea + 16'd1;
        nx_wdata = base_reg[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= nxt;
      mem_req   <= nx_req;
      mem_we    <= nx_we;
      mem_addr  <= nx_addr;
      mem_wdata <= nx_wdata;
      if (nxt != state)  wcnt <= '0;
      else if (mem_req)  wcnt <= wcnt + 1'b1;
      if (nxt == S_FIN)  err_q <= (state != S_EXEC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q  <= OPC_LD;
      ea_q   <= '0;
      reg_q  <= '0;
      opnd_q <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      result <= '0;
      cc_out <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cls_q  <= op_class(op, op6, page2,
                           page3, is_store);
        ea_q   <= ea;
        reg_q  <= reg_val;
        opnd_q <= is_store ? reg_val : imm_val;
        c_q    <= cc_in[CC_C];
        v_q    <= cc_in[CC_V];
      end
      if (state == S_RD_HI && mem_ack)
        opnd_q[15:8] <= mem_rdata;
      if (state == S_RD_LO && mem_ack)
        opnd_q[7:0] <= mem_rdata;
      if (state == S_EXEC) begin
        result <= alu_out;
        cc_out[CC_N] <= alu_n;
        cc_out[CC_Z] <= alu_z;
        cc_out[CC_V] <= (cls_q == OPC_LD ||
                         cls_q == OPC_ST) ? 1'b0 : alu_v;
        cc_out[CC_C] <= alu_c;
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_FIN);
  assign err   = done && err_q;
  assign wb_en = done && !err_q &&
                 (cls_q != OPC_ST) && (cls_q != OPC_CMP);

endmodule
